nibble_serial_adder: RTL and testbench
======================================

# nibble_serial_adder

Multi-precision adder/subtractor controller that sequences a single shared 4-bit ripple-carry adder over `WIDTH/4` clock cycles, least-significant nibble first, with a registered carry between nibbles. It sits between a requesting datapath and the team's existing `ripple_carry_adder_4bit`. Wide add/sub is traded for latency with a `start`/`ready`/`done` handshake.

## Interface
- `WIDTH`, default 16: operand/result width. Must be a multiple of 4 and at least 4. `N = WIDTH/4` nibble steps.
- `clk`  in  1  sole clock. All state changes on the rising edge.
- `rst`  in  1  reset. One clock; reset is synchronous and active-high.
- `start`  in  1  request. Accepted only when `ready` = 1.
- `sub`  in  1  0 = a+b, 1 = a−b. Sampled with `start`.
- `a`  in  WIDTH  operand A. Sampled with `start`.
- `b`  in  WIDTH  operand B. Sampled with `start`.
- `ready`  out  1  high in IDLE only.
- `done`  out  1  one-cycle pulse; results valid.
- `sum`  out  WIDTH  result (mod 2^WIDTH).
- `c_out`  out  1  carry out of MSB. For subtract this is not-borrow.
- `ovf`  out  1  two's-complement overflow.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - `ready` = 1.
  - On `start` = 1: latch `a` into `a_q`, latch `b_eff = sub ? ~b : b` into `b_q`, set `carry_q = sub`, set `idx = 0`, go to RUN.
- **RUN**
  - Adder inputs: `a_q[4*idx+3:4*idx]`, `b_q` nibble `idx`, `c_in = carry_q`.
  - Each edge: write the adder sum nibble into working register `w_q` at `idx`, set `carry_q` to the adder `c_out`, increment `idx`.
  - When `idx == N-1`, the edge instead:
    - copies the completed `w_q` into `sum`;
    - loads `c_out` from the adder `c_out`;
    - loads `ovf = (a_q[MSB] == b_q[MSB]) && (final sum[MSB] != a_q[MSB])`;
    - goes to DONE.
- **DONE**: `done` = 1 for exactly one cycle, `ready` = 0, then IDLE unconditionally.
- `start` is ignored whenever `ready` = 0, including in DONE. No queuing.
- `sum`, `c_out` and `ovf` hold their last completed values until the next completion. They do not change during RUN.
- `a`, `b` and `sub` may change freely after acceptance.
- `WIDTH` = 4: RUN lasts one cycle (`idx` is always 0).
- Arithmetic is unsigned modulo 2^WIDTH. `ovf` is meaningful for signed interpretation only.
- `idx` width is `max(1, $clog2(N))`. It never exceeds N−1.

## Timing
- After a reset edge:
  - state = IDLE, `ready` = 1, `done` = 0;
  - `sum` = 0, `c_out` = 0, `ovf` = 0;
  - `w_q`, `carry_q` and `idx` = 0.
- `start` sampled at edge E0 puts the block in RUN for edges E1..EN.
- Results update at EN. `done` is high in the cycle after EN.
- `ready` returns at edge EN+1.
- Request-to-`done` latency: N cycles. Throughput: one operation per N+2 cycles.
- `rst` wins over everything. Reset asserted mid-RUN or in DONE aborts the operation with no `done` pulse, and all outputs take their reset values at that edge.
- `start` coincident with `rst`: ignored.

## Structure
- Shared package holds:
  - the state enum `{IDLE, RUN, DONE}`;
  - constant `NIBBLE = 4`;
  - a function computing N and the `idx` width from `WIDTH`.
- One sub-module only: a single `ripple_carry_adder_4bit` instance, fed by the nibble mux.
- All sequencing, muxing and result registers live in `nibble_serial_adder`.

## Test plan
All scenarios use `WIDTH` = 16 (N = 4).
- **Reset:** hold `rst` 2 cycles -> `ready`=1, `done`=0, `sum`=0x0000, `c_out`=0, `ovf`=0.
- **Plain add:** `a`=0x1234, `b`=0x0FFF, `sub`=0, one-cycle `start` -> `done` exactly 4 cycles after the accept edge; `sum`=0x2233, `c_out`=0, `ovf`=0. `ready` low for 5 cycles.
- **Wrap-around:** `a`=0xFFFF, `b`=0x0001, add -> `sum`=0x0000, `c_out`=1, `ovf`=0.
  - Then `a`=0x7FFF, `b`=0x0001 -> `sum`=0x8000, `c_out`=0, `ovf`=1.
- **Subtract:**
  - `a`=0x8000, `b`=0x0001, `sub`=1 -> `sum`=0x7FFF, `c_out`=1, `ovf`=1.
  - `a`=0x0003, `b`=0x0005, `sub`=1 -> `sum`=0xFFFE, `c_out`=0, `ovf`=0.
- **Busy handling:** hold `start`=1 continuously with changing `a`/`b`. Required:
  - only IDLE-cycle values are accepted;
  - exactly one `done` per N+2 cycles;
  - `sum` stays stable between `done` pulses.
- **Reset mid-operation:** assert `rst` at edge E2 of an add -> `ready`=1 and `sum`=0 at the next cycle, with no `done` pulse. A following 0x0001+0x0002 request returns `sum`=0x0003.

Source files
------------

// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and sizing helpers for the nibble-serial adder.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
`timescale 1ns/1ps
package nibble_serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIBBLE = 4;

  // Number of nibble steps needed to cover a WIDTH-bit operand.
  function automatic int nib_count(input int width);
    return width / NIBBLE;
  endfunction

  // Step-index width; a single-step adder still gets a 1-bit index.
  function automatic int idx_width(input int width);
    int n;
    n = width / NIBBLE;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_rca.sv
// Combinational 4-bit ripple-carry adder shared by the serial sequencer.
// Latency: zero cycles, purely combinational.
// Backpressure: none; output follows inputs.
`timescale 1ns/1ps
module ripple_carry_adder_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out
);

  // Ripple the carry through four full-adder bit slices.
  always_comb begin
    logic c;
    sum = '0;
    c   = c_in;
    for (int i = 0; i < 4; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    c_out = c;
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide add/sub built by stepping one 4-bit adder over WIDTH/4 cycles, LSB nibble first.
// Latency: WIDTH/4 cycles from accepted start to done; one op per WIDTH/4+2 cycles.
// Backpressure: start is only taken while ready is high; requests while busy are dropped.
`timescale 1ns/1ps
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int N  = nib_count(WIDTH);
  localparam int IW = idx_width(WIDTH);
  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

  state_t            state_q;
  state_t            state_d;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [WIDTH-1:0]  w_q;
  logic [WIDTH-1:0]  w_next;
  logic              carry_q;
  logic [IW-1:0]     idx;
  logic [NIBBLE-1:0] nib_a;
  logic [NIBBLE-1:0] nib_b;
  logic [NIBBLE-1:0] nib_sum;
  logic              nib_cout;
  logic              last_step;

  assign last_step = (idx == IDX_LAST);

  // State register; reset returns to IDLE and drops any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: RUN until the top nibble is processed, then a single DONE cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_step) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded straight from the state.
  always_comb begin
    ready = (state_q == IDLE);
    done  = (state_q == DONE);
  end

  // Select the current nibble of each operand and splice the adder result into the working word.
  always_comb begin
    nib_a  = '0;
    nib_b  = '0;
    w_next = w_q;
    for (int i = 0; i < N; i++) begin
      if (idx == IW'(i)) begin
        nib_a                          = a_q[i*NIBBLE +: NIBBLE];
        nib_b                          = b_q[i*NIBBLE +: NIBBLE];
        w_next[i*NIBBLE +: NIBBLE]     = nib_sum;
      end
    end
  end

  ripple_carry_adder_4bit u_rca (
    .a     (nib_a),
    .b     (nib_b),
    .c_in  (carry_q),
    .sum   (nib_sum),
    .c_out (nib_cout)
  );

  // Operand capture, per-nibble accumulation and result publication on the final step.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      w_q     <= '0;
      carry_q <= 1'b0;
      idx     <= '0;
      sum     <= '0;
      c_out   <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            // Subtract is a + ~b + 1: invert B once here and seed the carry with sub.
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub;
            idx     <= '0;
          end
        end
        RUN: begin
          w_q     <= w_next;
          carry_q <= nib_cout;
          if (last_step) begin
            sum   <= w_next;
            c_out <= nib_cout;
            ovf   <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (w_next[WIDTH-1] != a_q[WIDTH-1]);
            idx   <= '0;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder at WIDTH=16.
// Latency: expects done 4 cycles after accept, ready low for 5 cycles.
// Backpressure: holds start high while busy to confirm requests are dropped.
`timescale 1ns/1ps
module tb_nibble_serial_adder;

  localparam int W = 16;
  localparam int N = 4;

  typedef struct {
    logic [W-1:0] sum;
    logic         c;
    logic         ovf;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    exp_t         e;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;
  logic         ovf;

  int   total = 0;
  int   bad   = 0;
  int   busy_left = 0;
  logic use_table = 1'b1;
  exp_t cur_exp;
  exp_t hold;
  exp_t exp_q[$];
  vec_t vecs[11];

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .ready (ready),
    .done  (done),
    .sum   (sum),
    .c_out (c_out),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
    end
  endtask

  // Independent reference: signed range check for overflow, unsigned compare for not-borrow.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    exp_t r;
    int sx;
    int sy;
    int res;
    logic [W:0] wide;
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (s) begin
      res   = sx - sy;
      r.sum = x - y;
      r.c   = (x >= y);
    end else begin
      res   = sx + sy;
      wide  = {1'b0, x} + {1'b0, y};
      r.sum = wide[W-1:0];
      r.c   = wide[W];
    end
    r.ovf = (res > 32767) || (res < -32768);
    return r;
  endfunction

  // Scoreboard: predicts accepts, ready/done timing, and checks results and output stability.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1) begin
      busy_left = 0;
      exp_q.delete();
      hold = '{sum: '0, c: 1'b0, ovf: 1'b0};
    end else begin
      check("ready", 32'(ready), 32'(busy_left == 0));
      check("done_timing", 32'(done), 32'(busy_left == 1));
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("done_without_request", 32'(done), 32'(0));
        end else begin
          e = exp_q.pop_front();
          check("sum", 32'(sum), 32'(e.sum));
          check("c_out", 32'(c_out), 32'(e.c));
          check("ovf", 32'(ovf), 32'(e.ovf));
          hold = e;
        end
      end else begin
        check("sum_stable", 32'(sum), 32'(hold.sum));
        check("c_out_stable", 32'(c_out), 32'(hold.c));
        check("ovf_stable", 32'(ovf), 32'(hold.ovf));
      end
      if (busy_left == 0 && start === 1'b1) begin
        exp_q.push_back(use_table ? cur_exp : model(a, b, sub));
        busy_left = N + 1;
      end else if (busy_left > 0) begin
        busy_left--;
      end
    end
  end

  task automatic issue(input vec_t v);
    int guard;
    guard = 0;
    @(negedge clk);
    while (ready !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (ready !== 1'b1) begin
      check("issue_wait_ready", 32'(ready), 32'(1));
      return;
    end
    @(posedge clk);
    #1;
    a         = v.a;
    b         = v.b;
    sub       = v.sub;
    cur_exp   = v.e;
    use_table = 1'b1;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    cur_exp = '{sum: '0, c: 1'b0, ovf: 1'b0};

    vecs[0]  = '{16'h1234, 16'h0FFF, 1'b0, '{16'h2233, 1'b0, 1'b0}};
    vecs[1]  = '{16'hFFFF, 16'h0001, 1'b0, '{16'h0000, 1'b1, 1'b0}};
    vecs[2]  = '{16'h7FFF, 16'h0001, 1'b0, '{16'h8000, 1'b0, 1'b1}};
    vecs[3]  = '{16'h8000, 16'h0001, 1'b1, '{16'h7FFF, 1'b1, 1'b1}};
    vecs[4]  = '{16'h0003, 16'h0005, 1'b1, '{16'hFFFE, 1'b0, 1'b0}};
    vecs[5]  = '{16'h0000, 16'h0000, 1'b0, '{16'h0000, 1'b0, 1'b0}};
    vecs[6]  = '{16'h8000, 16'h8000, 1'b0, '{16'h0000, 1'b1, 1'b1}};
    vecs[7]  = '{16'h0005, 16'h0005, 1'b1, '{16'h0000, 1'b1, 1'b0}};
    vecs[8]  = '{16'h00F0, 16'h0010, 1'b0, '{16'h0100, 1'b0, 1'b0}};
    vecs[9]  = '{16'h0FFF, 16'h0001, 1'b0, '{16'h1000, 1'b0, 1'b0}};
    vecs[10] = '{16'h0000, 16'h0001, 1'b1, '{16'hFFFF, 1'b0, 1'b0}};

    // Reset held for two cycles, then explicit reset-state checks.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(ready), 32'(1));
    check("rst_done", 32'(done), 32'(0));
    check("rst_sum", 32'(sum), 32'(16'h0000));
    check("rst_c_out", 32'(c_out), 32'(0));
    check("rst_ovf", 32'(ovf), 32'(0));

    // Table-driven vectors.
    for (int i = 0; i < 11; i++) issue(vecs[i]);

    // Busy handling: start held high with operands changing every cycle.
    repeat (8) @(negedge clk);
    @(posedge clk);
    #1;
    use_table = 1'b0;
    a     = 16'($urandom);
    b     = 16'($urandom);
    sub   = 1'($urandom);
    start = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      a   = 16'($urandom);
      b   = 16'($urandom);
      sub = 1'($urandom);
    end
    start = 1'b0;
    repeat (8) @(negedge clk);

    // Reset mid-operation: accept at E0, reset sampled at E2.
    @(posedge clk);
    #1;
    a = 16'h1111; b = 16'h2222; sub = 1'b0;
    cur_exp   = '{sum: 16'h3333, c: 1'b0, ovf: 1'b0};
    use_table = 1'b1;
    start     = 1'b1;
    @(posedge clk);   // E0
    #1 start = 1'b0;
    @(posedge clk);   // E1
    #1 rst = 1'b1;
    @(posedge clk);   // E2
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_ready", 32'(ready), 32'(1));
    check("midrst_sum", 32'(sum), 32'(16'h0000));
    check("midrst_done", 32'(done), 32'(0));
    repeat (8) @(negedge clk);
    issue('{16'h0001, 16'h0002, 1'b0, '{16'h0003, 1'b0, 1'b0}});

    // start coincident with reset is ignored.
    repeat (8) @(negedge clk);
    @(posedge clk);
    #1;
    rst   = 1'b1;
    start = 1'b1;
    a = 16'hAAAA; b = 16'h5555; sub = 1'b0;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("rst_start_ready", 32'(ready), 32'(1));
    check("rst_start_sum", 32'(sum), 32'(16'h0000));

    repeat (10) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout reached at t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
